mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the unified byte-addressed instruction/data memory (4 KiB, combinational read, write on rising clock edge). It sits between the core's instruction-fetch unit and load/store unit and the single memory port. It accepts one access per cycle, registers the address and control it drives into the memory, and returns read data one cycle after the access. Data accesses have priority over fetches, optionally with a starvation guard.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bus bundle between the instruction-fetch unit, the
// load/store unit, the unified memory port and mem_arbiter.
//   slave  : view taken by the arbiter
//   master : view taken by the requesters and the memory
interface mem_arbiter_if;
   // instruction-fetch port
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   // load/store port
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   // memory port
   logic        memory_write;
   logic [31:0] memory_addr;
   logic [1:0]  memory_size;
   logic        memory_unsigned;
   logic [31:0] memory_data_in;
   logic [31:0] memory_data_out;

   modport slave (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output memory_write, memory_addr, memory_size, memory_unsigned, memory_data_in,
      input  memory_data_out
   );

   modport master (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  memory_write, memory_addr, memory_size, memory_unsigned, memory_data_in,
      output memory_data_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter/sequencer for the unified 4 KiB
// instruction/data memory. One access is selected per clock; data wins over
// fetch. The selected access is registered onto the memory port during the
// following cycle and its response is registered one cycle later (2-cycle
// latency, no bubble between back-to-back accesses).
//
// Optional feature macro: MEM_ARB_FAIR_EN
//   defined   : starvation guard, a fetch is forced through after STARVE_MAX
//               consecutive data grants made while a fetch was waiting
//   undefined : strict data priority, no counter
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned ADDR_LIMIT = 4096
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      I_ACC = 2'b01,
      D_ACC = 2'b10,
      D_ERR = 2'b11
   } state_t;

   state_t      state_r;
   state_t      state_s;

   logic        sel_i_s;
   logic        sel_d_s;
   logic        d_bad_s;
   logic        force_i_s;

   logic        i_gnt_r;
   logic        i_rvalid_r;
   logic [31:0] i_rdata_r;
   logic        d_gnt_r;
   logic        d_rvalid_r;
   logic [31:0] d_rdata_r;
   logic        d_err_r;

   logic        memory_write_r;
   logic [31:0] memory_addr_r;
   logic [1:0]  memory_size_r;
   logic        memory_unsigned_r;
   logic [31:0] memory_data_in_r;

   // A data request is rejected for an illegal size, a misaligned half or
   // word, or when its last byte lands at or beyond ADDR_LIMIT. The end
   // address is computed one bit wider so a wrap past 2^32 still errors.
   function automatic logic d_req_bad(input logic [1:0] size, input logic [31:0] addr);
      logic        bad;
      logic [32:0] last;
      case (size)
         2'b00: begin
            bad  = 1'b0;
            last = {1'b0, addr};
         end
         2'b01: begin
            bad  = addr[0];
            last = {1'b0, addr} + 33'd1;
         end
         2'b10: begin
            bad  = (addr[1:0] != 2'b00);
            last = {1'b0, addr} + 33'd3;
         end
         default: begin
            bad  = 1'b1;
            last = {1'b0, addr};
         end
      endcase
      if (last >= 33'(ADDR_LIMIT)) begin
         bad = 1'b1;
      end else begin
         bad = bad;
      end
      return bad;
   endfunction

`ifdef MEM_ARB_FAIR_EN
   logic [2:0] starve_cnt_r;
   logic [2:0] starve_cnt_s;

   // Fetch is forced through once the data side has used up its allowance.
   always_comb begin
      force_i_s = bus.i_req && (starve_cnt_r == 3'(STARVE_MAX));
   end

   // Count data grants made while a fetch waits; clear on fetch grant or no fetch.
   always_comb begin
      starve_cnt_s = starve_cnt_r;
      if (!bus.i_req) begin
         starve_cnt_s = 3'd0;
      end else if (sel_i_s) begin
         starve_cnt_s = 3'd0;
      end else if (sel_d_s && (starve_cnt_r != 3'd7)) begin
         starve_cnt_s = starve_cnt_r + 3'd1;
      end else begin
         starve_cnt_s = starve_cnt_r;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= 3'd0;
      end else begin
         starve_cnt_r <= starve_cnt_s;
      end
   end
`else
   // Strict data priority: a fetch is never forced ahead of a data request.
   always_comb begin
      force_i_s = 1'b0;
   end
`endif

   // Selection and next state: every access lasts one cycle, so a new winner
   // is picked at every edge.
   always_comb begin
      sel_i_s = 1'b0;
      sel_d_s = 1'b0;
      state_s = IDLE;
      d_bad_s = d_req_bad(bus.d_size, bus.d_addr);
      if (bus.d_req && !force_i_s) begin
         sel_d_s = 1'b1;
         if (d_bad_s) begin
            state_s = D_ERR;
         end else begin
            state_s = D_ACC;
         end
      end else if (bus.i_req) begin
         sel_i_s = 1'b1;
         state_s = I_ACC;
      end else begin
         state_s = IDLE;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Grants: high for the cycle following the edge that accepted the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_gnt_r <= 1'b0;
         d_gnt_r <= 1'b0;
      end else begin
         i_gnt_r <= sel_i_s;
         d_gnt_r <= sel_d_s;
      end
   end

   // Latch the winner onto the memory port; errored and idle cycles never write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memory_write_r    <= 1'b0;
         memory_addr_r     <= 32'h0000_0000;
         memory_size_r     <= 2'b10;
         memory_unsigned_r <= 1'b0;
         memory_data_in_r  <= 32'h0000_0000;
      end else if (sel_d_s) begin
         memory_write_r    <= bus.d_we && !d_bad_s;
         memory_addr_r     <= bus.d_addr;
         memory_size_r     <= bus.d_size;
         memory_unsigned_r <= bus.d_unsigned;
         memory_data_in_r  <= bus.d_wdata;
      end else if (sel_i_s) begin
         memory_write_r    <= 1'b0;
         memory_addr_r     <= bus.i_addr;
         memory_size_r     <= 2'b10;
         memory_unsigned_r <= 1'b0;
      end else begin
         memory_write_r    <= 1'b0;
      end
   end

   // Fetch response: capture memory read data at the end of a fetch cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_rvalid_r <= 1'b0;
         i_rdata_r  <= 32'h0000_0000;
      end else if (state_r == I_ACC) begin
         i_rvalid_r <= 1'b1;
         i_rdata_r  <= bus.memory_data_out;
      end else begin
         i_rvalid_r <= 1'b0;
      end
   end

   // Data response: load data, zero for stores, zero with d_err for rejects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_rvalid_r <= 1'b0;
         d_err_r    <= 1'b0;
         d_rdata_r  <= 32'h0000_0000;
      end else begin
         case (state_r)
            D_ACC: begin
               d_rvalid_r <= 1'b1;
               d_err_r    <= 1'b0;
               if (memory_write_r) begin
                  d_rdata_r <= 32'h0000_0000;
               end else begin
                  d_rdata_r <= bus.memory_data_out;
               end
            end
            D_ERR: begin
               d_rvalid_r <= 1'b1;
               d_err_r    <= 1'b1;
               d_rdata_r  <= 32'h0000_0000;
            end
            default: begin
               d_rvalid_r <= 1'b0;
               d_err_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.i_gnt           = i_gnt_r;
   assign bus.i_rvalid        = i_rvalid_r;
   assign bus.i_rdata         = i_rdata_r;
   assign bus.d_gnt           = d_gnt_r;
   assign bus.d_rvalid        = d_rvalid_r;
   assign bus.d_rdata         = d_rdata_r;
   assign bus.d_err           = d_err_r;
   assign bus.memory_write    = memory_write_r;
   assign bus.memory_addr     = memory_addr_r;
   assign bus.memory_size     = memory_size_r;
   assign bus.memory_unsigned = memory_unsigned_r;
   assign bus.memory_data_in  = memory_data_in_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter with a behavioural 4 KiB
// little-endian memory and response scoreboards for both requesters.
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } d_exp_t;

`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk;
   logic rst;

   mem_arbiter_if bus();

   mem_arbiter #(
      .STARVE_MAX (4),
      .ADDR_LIMIT (4096)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;

   logic [31:0] iq[$];
   d_exp_t      dq[$];

   // ---------------- behavioural memory ----------------
   logic [7:0]  mem [0:4095];
   logic        bd_we;
   logic [11:0] bd_addr;
   logic [7:0]  bd_data;
   logic [11:0] ra;

   always_comb begin
      ra = bus.memory_addr[11:0];
      case (bus.memory_size)
         2'b00: bus.memory_data_out = bus.memory_unsigned ? {24'h000000, mem[ra]}
                                                          : {{24{mem[ra][7]}}, mem[ra]};
         2'b01: bus.memory_data_out = bus.memory_unsigned ? {16'h0000, mem[12'(ra + 12'd1)], mem[ra]}
                                                          : {{16{mem[12'(ra + 12'd1)][7]}}, mem[12'(ra + 12'd1)], mem[ra]};
         default: bus.memory_data_out = {mem[12'(ra + 12'd3)], mem[12'(ra + 12'd2)],
                                         mem[12'(ra + 12'd1)], mem[ra]};
      endcase
   end

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (bus.memory_write) begin
         mem[bus.memory_addr[11:0]] <= bus.memory_data_in[7:0];
         if (bus.memory_size != 2'b00)
            mem[12'(bus.memory_addr[11:0] + 12'd1)] <= bus.memory_data_in[15:8];
         if (bus.memory_size == 2'b10) begin
            mem[12'(bus.memory_addr[11:0] + 12'd2)] <= bus.memory_data_in[23:16];
            mem[12'(bus.memory_addr[11:0] + 12'd3)] <= bus.memory_data_in[31:24];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   task automatic i_access(input logic [31:0] addr, input logic [31:0] exp_rdata);
      @(negedge clk);
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
      iq.push_back(exp_rdata);
      @(posedge clk);
      #1;
      check("i_gnt", bus.i_gnt, 32'd1);
   endtask

   task automatic d_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
      d_exp_t e;
      @(negedge clk);
      bus.d_req      = 1'b1;
      bus.d_we       = we;
      bus.d_size     = size;
      bus.d_unsigned = uns;
      bus.d_addr     = addr;
      bus.d_wdata    = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      dq.push_back(e);
      @(posedge clk);
      #1;
      check("d_gnt", bus.d_gnt, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((iq.size() != 0 || dq.size() != 0) && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
      check("drain_i_queue", iq.size(), 32'd0);
      check("drain_d_queue", dq.size(), 32'd0);
   endtask

   // ---------------- response monitor ----------------
   initial begin
      logic [31:0] ie;
      d_exp_t      de;
      forever begin
         @(negedge clk);
         if (bus.memory_write === 1'b1) wr_cnt++;
         if (bus.i_rvalid === 1'b1) begin
            if (iq.size() == 0) begin
               check("i_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
               ie = iq.pop_front();
               check("i_rdata", bus.i_rdata, ie);
            end
         end
         if (bus.d_rvalid === 1'b1) begin
            if (dq.size() == 0) begin
               check("d_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
               de = dq.pop_front();
               check("d_rdata", bus.d_rdata, de.rdata);
               check("d_err", {31'd0, bus.d_err}, {31'd0, de.err});
            end
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int wr_before;
      logic exp_i;

      rst            = 1'b1;
      bd_we          = 1'b0;
      bd_addr        = 12'h000;
      bd_data        = 8'h00;
      bus.i_req      = 1'b0;
      bus.i_addr     = 32'h0;
      bus.d_req      = 1'b0;
      bus.d_we       = 1'b0;
      bus.d_size     = 2'b10;
      bus.d_unsigned = 1'b0;
      bus.d_addr     = 32'h0;
      bus.d_wdata    = 32'h0;

      // preload: instruction at 0x10, last word of memory, marker at 0x200
      bd_write(12'h010, 8'h93); bd_write(12'h011, 8'h00);
      bd_write(12'h012, 8'hA0); bd_write(12'h013, 8'h00);
      bd_write(12'hFFC, 8'h11); bd_write(12'hFFD, 8'h22);
      bd_write(12'hFFE, 8'h33); bd_write(12'hFFF, 8'h44);
      bd_write(12'h200, 8'h5A);

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_i_gnt",      {31'd0, bus.i_gnt},           32'd0);
      check("rst_d_gnt",      {31'd0, bus.d_gnt},           32'd0);
      check("rst_i_rvalid",   {31'd0, bus.i_rvalid},        32'd0);
      check("rst_d_rvalid",   {31'd0, bus.d_rvalid},        32'd0);
      check("rst_d_err",      {31'd0, bus.d_err},           32'd0);
      check("rst_i_rdata",    bus.i_rdata,                  32'd0);
      check("rst_d_rdata",    bus.d_rdata,                  32'd0);
      check("rst_mem_write",  {31'd0, bus.memory_write},    32'd0);
      check("rst_mem_addr",   bus.memory_addr,              32'd0);
      check("rst_mem_size",   {30'd0, bus.memory_size},     32'd2);
      check("rst_mem_uns",    {31'd0, bus.memory_unsigned}, 32'd0);
      check("rst_mem_din",    bus.memory_data_in,           32'd0);

      // fetch: gnt and address in E+1, data in E+2
      i_access(32'h0000_0010, 32'h00A0_0093);
      check("fetch_mem_addr",  bus.memory_addr,          32'h0000_0010);
      check("fetch_mem_size",  {30'd0, bus.memory_size}, 32'd2);
      check("fetch_mem_write", {31'd0, bus.memory_write}, 32'd0);
      idle();
      @(posedge clk);
      #1;
      check("fetch_rvalid_e2", {31'd0, bus.i_rvalid}, 32'd1);
      check("fetch_rdata_e2",  bus.i_rdata,           32'h00A0_0093);
      drain();

      // store word then back-to-back byte loads (signed, unsigned) and a half
      d_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
      check("store_mem_write", {31'd0, bus.memory_write}, 32'd1);
      d_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFEF, 1'b0);
      d_access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 32'h0000_00EF, 1'b0);
      d_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_DEAD, 1'b0);
      d_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
      idle();
      drain();

      // errors never touch memory; legal accesses at the top boundary
      wr_before = wr_cnt;
      d_access(1'b1, 2'b10, 1'b0, 32'h102, 32'h1234_5678, 32'h0, 1'b1);
      check("err_no_write", {31'd0, bus.memory_write}, 32'd0);
      d_access(1'b0, 2'b01, 1'b0, 32'hFFF, 32'h0, 32'h0, 1'b1);
      d_access(1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1);
      d_access(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
      d_access(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'h4433_2211, 1'b0);
      d_access(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 32'h0000_0044, 1'b0);
      idle();
      drain();
      check("err_write_count", wr_cnt - wr_before, 32'd0);

      // both requesters held for ten selections
      @(negedge clk);
      bus.i_req      = 1'b1;
      bus.i_addr     = 32'h10;
      bus.d_req      = 1'b1;
      bus.d_we       = 1'b0;
      bus.d_size     = 2'b10;
      bus.d_unsigned = 1'b0;
      bus.d_addr     = 32'h100;
      for (int k = 0; k < 10; k++) begin
         d_exp_t e;
         exp_i = FAIR && ((k % 5) == 4);
         if (exp_i) begin
            iq.push_back(32'h00A0_0093);
         end else begin
            e.rdata = 32'hDEAD_BEEF;
            e.err   = 1'b0;
            dq.push_back(e);
         end
         @(posedge clk);
         #1;
         check("arb_i_gnt", {31'd0, bus.i_gnt}, {31'd0, exp_i});
         check("arb_d_gnt", {31'd0, bus.d_gnt}, {31'd0, !exp_i});
         if (k != 9) @(negedge clk);
      end
      idle();
      drain();

      // asynchronous reset during the access cycle of a store
      d_access(1'b1, 2'b10, 1'b0, 32'h200, 32'h1122_3344, 32'h0, 1'b0);
      check("rst_store_write", {31'd0, bus.memory_write}, 32'd1);
      void'(dq.pop_back());
      #2;
      rst = 1'b1;
      #1;
      check("arst_mem_write", {31'd0, bus.memory_write}, 32'd0);
      check("arst_d_gnt",     {31'd0, bus.d_gnt},        32'd0);
      check("arst_mem_addr",  bus.memory_addr,           32'd0);
      check("arst_mem_size",  {30'd0, bus.memory_size},  32'd2);
      check("arst_mem_din",   bus.memory_data_in,        32'd0);
      check("arst_d_rdata",   bus.d_rdata,               32'd0);
      idle();
      @(posedge clk);
      #1;
      check("arst_no_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
      check("arst_mem_byte",  {24'd0, mem[12'h200]}, 32'h0000_005A);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_no_rvalid_after", {31'd0, bus.d_rvalid}, 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
